// File: rtl/dp_pkg.sv
// dp_pkg: ALU op codes, FSM states and latched control bundle for multicycle_datapath
package dp_pkg;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
    typedef struct packed {
        logic       regwrite;
        logic       regdst;
        logic       extop;
        logic       alusrc;
        logic       memwrite;
        logic       mem2reg;
        logic [3:0] aluctrl;
    } ctrl_t;
endpackage

// File: rtl/dp_regfile.sv
// dp_regfile: register file with two async read ports, a debug read port, one sync write port, r0 hardwired to 0
module dp_regfile #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] raddr1,
    input  logic [REG_ADDR_W-1:0] raddr2,
    input  logic [REG_ADDR_W-1:0] dbg_raddr,
    output logic [DATA_W-1:0]     rdata1,
    output logic [DATA_W-1:0]     rdata2,
    output logic [DATA_W-1:0]     dbg_rdata,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata
);
    localparam int N = 2 ** REG_ADDR_W;
    logic [DATA_W-1:0] regs_q [N];
    logic [DATA_W-1:0] regs_d [N];
    always_comb begin
        regs_d = regs_q;
        if (we && waddr != '0) regs_d[waddr] = wdata;
    end
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) regs_q[i] <= rst ? '0 : regs_d[i];
    end
    assign rdata1    = raddr1 == '0 ? '0 : regs_q[raddr1];
    assign rdata2    = raddr2 == '0 ? '0 : regs_q[raddr2];
    assign dbg_rdata = dbg_raddr == '0 ? '0 : regs_q[dbg_raddr];
endmodule

// File: rtl/multicycle_datapath.sv
// multicycle_datapath: DECODE/EXEC/MEM/WB MIPS datapath with req/ack data memory; optional DATAPATH_OVF_TRAP_EN
module multicycle_datapath
    import dp_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int MEM_ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_valid,
    output logic                  inst_ready,
    input  logic [31:0]           inst,
    input  logic                  regwrite,
    input  logic                  regdst,
    input  logic                  extop,
    input  logic                  alusrc,
    input  logic                  memwrite,
    input  logic                  mem2reg,
    input  logic [3:0]            aluctrl,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ack,
    output logic                  zero,
    output logic                  msb,
    output logic                  done,
    output logic                  ovf_trap,
    input  logic [REG_ADDR_W-1:0] dbg_raddr,
    output logic [DATA_W-1:0]     dbg_rdata
);
    localparam int M = DATA_W - 1;
    state_t            state_q, state_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [25:0]       inst_q, inst_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, ext_q, ext_d, res_q, res_d, load_q, load_d;
    logic              zero_q, zero_d, msb_q, msb_d, ovf_q, ovf_d;
    logic              done_q, done_d, mem_req_q, mem_req_d, mem_we_q, mem_we_d, trap_q, trap_d;
    logic [DATA_W-1:0] rdata1, rdata2, op_b, sum, diff, alu_res;
    logic              ovf;
    logic              unused_inst;
    assign unused_inst = ^inst[31:26];
    dp_regfile #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .raddr1   (inst_q[21 +: REG_ADDR_W]),
        .raddr2   (inst_q[16 +: REG_ADDR_W]),
        .dbg_raddr(dbg_raddr),
        .rdata1   (rdata1),
        .rdata2   (rdata2),
        .dbg_rdata(dbg_rdata),
        .we       (state_q == S_WB && ctrl_q.regwrite && !ovf_q),
        .waddr    (ctrl_q.regdst ? inst_q[11 +: REG_ADDR_W] : inst_q[16 +: REG_ADDR_W]),
        .wdata    (ctrl_q.mem2reg ? load_q : res_q)
    );
    assign op_b    = ctrl_q.alusrc ? ext_q : b_q;
    assign sum     = a_q + op_b;
    assign diff    = a_q - op_b;
    assign alu_res = ctrl_q.aluctrl == ALU_AND ? a_q & op_b :
                     ctrl_q.aluctrl == ALU_OR  ? a_q | op_b :
                     ctrl_q.aluctrl == ALU_ADD ? sum :
                     ctrl_q.aluctrl == ALU_SUB ? diff :
                     ctrl_q.aluctrl == ALU_SLT ? DATA_W'($signed(a_q) < $signed(op_b)) :
                     ctrl_q.aluctrl == ALU_NOR ? ~(a_q | op_b) : '0;
`ifdef DATAPATH_OVF_TRAP_EN
    assign ovf = ctrl_q.aluctrl == ALU_ADD ? a_q[M] == op_b[M] && sum[M] != a_q[M] :
                 ctrl_q.aluctrl == ALU_SUB ? a_q[M] != op_b[M] && diff[M] != a_q[M] : 1'b0;
`else
    assign ovf = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        inst_d  = inst_q;
        a_d     = a_q;
        b_d     = b_q;
        ext_d   = ext_q;
        res_d   = res_q;
        load_d  = load_q;
        zero_d  = zero_q;
        msb_d   = msb_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: if (inst_valid) begin
                state_d = S_DECODE;
                inst_d  = inst[25:0];
                ctrl_d  = {regwrite, regdst, extop, alusrc, memwrite, mem2reg, aluctrl};
            end
            S_DECODE: begin
                state_d = S_EXEC;
                a_d     = rdata1;
                b_d     = rdata2;
                ext_d   = ctrl_q.extop ? DATA_W'($signed(inst_q[15:0])) : DATA_W'(inst_q[15:0]);
            end
            S_EXEC: begin
                state_d = ctrl_q.memwrite || ctrl_q.mem2reg ? S_MEM : S_WB;
                res_d   = alu_res;
                zero_d  = alu_res == '0;
                msb_d   = alu_res[M];
                ovf_d   = ovf;
            end
            S_MEM: if (mem_ack) begin
                state_d = S_WB;
                load_d  = mem_rdata;
            end
            default: state_d = S_IDLE;
        endcase
        mem_req_d = state_d == S_MEM;
        mem_we_d  = mem_req_d && ctrl_q.memwrite;
        done_d    = state_d == S_WB;
        trap_d    = done_d && ovf_d;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ctrl_q    <= '0;
            inst_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            ext_q     <= '0;
            res_q     <= '0;
            load_q    <= '0;
            zero_q    <= 1'b0;
            msb_q     <= 1'b0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            trap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            inst_q    <= inst_d;
            a_q       <= a_d;
            b_q       <= b_d;
            ext_q     <= ext_d;
            res_q     <= res_d;
            load_q    <= load_d;
            zero_q    <= zero_d;
            msb_q     <= msb_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
            mem_req_q <= mem_req_d;
            mem_we_q  <= mem_we_d;
            trap_q    <= trap_d;
        end
    end
    assign inst_ready = state_q == S_IDLE;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = res_q[MEM_ADDR_W+1:2];
    assign mem_wdata  = b_q;
    assign zero       = zero_q;
    assign msb        = msb_q;
    assign done       = done_q;
    assign ovf_trap   = trap_q;
endmodule

// File: tb/tb_multicycle_datapath.sv
// tb_multicycle_datapath: scoreboard bench with random instructions against an architectural model
module tb_multicycle_datapath;
    logic        clk = 0, rst = 1, inst_valid = 0;
    logic [31:0] inst = 0;
    logic        regwrite = 0, regdst = 0, extop = 0, alusrc = 0, memwrite = 0, mem2reg = 0;
    logic [3:0]  aluctrl = 0;
    logic        mem_ack = 0;
    logic [31:0] mem_rdata = 0;
    logic [4:0]  dbg_raddr, main_dbg = 0, mon_dbg = 0;
    logic        mon_en = 0;
    logic        inst_ready, mem_req, mem_we, zero, msb, done, ovf_trap;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, dbg_rdata;

    multicycle_datapath dut (
        .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .regwrite(regwrite), .regdst(regdst), .extop(extop), .alusrc(alusrc), .memwrite(memwrite),
        .mem2reg(mem2reg), .aluctrl(aluctrl), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .zero(zero), .msb(msb),
        .done(done), .ovf_trap(ovf_trap), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
    );

    assign dbg_raddr = mon_en ? mon_dbg : main_dbg;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef DATAPATH_OVF_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {int acc; int lat; bit zero; bit msb; bit trap; logic [4:0] dest; logic [31:0] val;} exp_t;
    typedef struct {bit we; logic [9:0] addr; logic [31:0] wdata;} mexp_t;
    exp_t        sb[$];
    mexp_t       mq[$];
    logic [31:0] mreg [32];
    logic [31:0] mem_arr [int];
    int          ack_wait = 0;
    int          vecs = 0, errs = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // monitor: every done pops one expectation; the destination register is read back one cycle later
    exp_t        me;
    bit          pend = 0;
    logic [31:0] pend_val;
    always @(negedge clk) begin
        if (pend) begin
            chk($sformatf("reg R%0d", mon_dbg), dbg_rdata, pend_val);
            pend = 0;
        end
        if (done) begin
            if (sb.size() == 0) begin
                vecs++; errs++;
                $display("FAIL unexpected done: got done=1 expected no instruction in flight");
            end else begin
                me = sb.pop_front();
                chk("latency", cyc - me.acc, me.lat);
                chk("zero", zero, me.zero);
                chk("msb", msb, me.msb);
                chk("ovf_trap", ovf_trap, me.trap);
                mon_dbg  = me.dest;
                pend_val = me.val;
                pend     = 1;
            end
        end
    end

    // memory responder: acks after ack_wait extra cycles, ack toggles randomly while no request
    int rcnt = 0;
    always @(negedge clk) begin
        if (mem_req) begin
            if (mq.size() == 0) begin
                vecs++; errs++;
                $display("FAIL unexpected mem_req: got 1 expected 0");
                mem_ack = 0;
            end else begin
                chk("mem_addr", mem_addr, mq[0].addr);
                chk("mem_we", mem_we, mq[0].we);
                chk("mem_wdata", mem_wdata, mq[0].wdata);
                if (rcnt == ack_wait) begin
                    mem_ack   = 1;
                    mem_rdata = mem_arr.exists(int'(mem_addr)) ? mem_arr[int'(mem_addr)] : $urandom;
                    void'(mq.pop_front());
                end else begin
                    mem_ack   = 0;
                    mem_rdata = $urandom;
                end
                rcnt++;
            end
        end else begin
            mem_ack = 1'($urandom_range(0, 1));
            rcnt    = 0;
        end
    end

    function automatic logic [31:0] alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return $signed(a) < $signed(b) ? 32'd1 : 32'd0;
            4'b1100: return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    task automatic issue(input bit rw, input bit rds, input bit eo, input bit as, input bit mw, input bit m2r,
                         input logic [3:0] c, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [15:0] imm, input int wt);
        int          n = 0;
        logic [31:0] a, b, ext, ob, res, lv;
        longint      s;
        bit          ovf, trap, mem;
        logic [9:0]  ad;
        logic [4:0]  dst;
        exp_t        e;
        @(negedge clk);
        while (!inst_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!inst_ready) begin
            vecs++; errs++;
            $display("FAIL inst_ready timeout: got 0 expected 1");
            return;
        end
        a   = mreg[rs];
        b   = mreg[rt];
        ext = eo ? {{16{imm[15]}}, imm} : {16'h0, imm};
        ob  = as ? ext : b;
        res = alu(c, a, ob);
        s   = c == 4'b0010 ? longint'($signed(a)) + longint'($signed(ob)) : longint'($signed(a)) - longint'($signed(ob));
        ovf = (c == 4'b0010 || c == 4'b0110) && s != longint'($signed(res));
        trap = TRAP && ovf;
        mem = mw || m2r;
        ad  = res[11:2];
        lv  = 0;
        if (mem) mq.push_back('{we: mw, addr: ad, wdata: b});
        if (mw) mem_arr[int'(ad)] = b;
        else if (m2r && !mem_arr.exists(int'(ad))) mem_arr[int'(ad)] = $urandom;
        if (m2r) lv = mem_arr[int'(ad)];
        dst = rds ? imm[15:11] : rt;
        if (rw && !trap && dst != 0) mreg[dst] = m2r ? lv : res;
        e = '{acc: cyc, lat: mem ? 4 + wt : 3, zero: res == 0, msb: res[31], trap: trap, dest: dst, val: mreg[dst]};
        sb.push_back(e);
        ack_wait = wt;
        {regwrite, regdst, extop, alusrc, memwrite, mem2reg, aluctrl} = {rw, rds, eo, as, mw, m2r, c};
        inst = {6'($urandom), rs, rt, imm};
        inst_valid = 1;
        @(negedge clk);
        inst_valid = 0;
        {regwrite, regdst, extop, alusrc, memwrite, mem2reg, aluctrl} = 10'($urandom);
    endtask

    initial begin
        int n;
        logic [3:0] ops [7];
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0011};
        for (int i = 0; i < 32; i++) mreg[i] = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        #1;
        chk("reset inst_ready", inst_ready, 1);
        chk("reset done", done, 0);
        chk("reset mem_req", mem_req, 0);
        chk("reset mem_we", mem_we, 0);
        chk("reset zero", zero, 0);
        chk("reset msb", msb, 0);
        chk("reset ovf_trap", ovf_trap, 0);
        for (int i = 0; i < 32; i++) begin
            main_dbg = 5'(i);
            #1;
            chk($sformatf("reset R%0d", i), dbg_rdata, 0);
        end
        mon_en = 1;
        // R1 = 0 + sext(FFFF)
        issue(1, 0, 1, 1, 0, 0, 4'b0010, 0, 1, 16'hFFFF, 0);
        // SW R1 -> word 2, ack on third request cycle, then zero-wait
        issue(0, 0, 1, 1, 1, 0, 4'b0010, 0, 1, 16'h0008, 2);
        issue(0, 0, 1, 1, 1, 0, 4'b0010, 0, 1, 16'h000C, 0);
        mem_arr[4] = 32'h12345678;
        issue(1, 0, 1, 1, 0, 1, 4'b0010, 0, 2, 16'h0010, 1);
        issue(1, 0, 1, 1, 0, 1, 4'b0010, 0, 0, 16'h0010, 0);
        // R1 = 7FFFFFFF via load, then R4 = R1 + 1 overflows
        mem_arr[5] = 32'h7FFFFFFF;
        issue(1, 0, 1, 1, 0, 1, 4'b0010, 0, 1, 16'h0014, 0);
        issue(1, 0, 1, 1, 0, 0, 4'b0010, 1, 4, 16'h0001, 0);
        // overflowing store still reaches memory
        issue(0, 0, 1, 1, 1, 0, 4'b0010, 1, 1, 16'h0001, 1);
        // reset while a load waits for ack
        issue(1, 0, 1, 1, 0, 1, 4'b0010, 0, 3, 16'h0018, 30);
        n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mem_req before reset", mem_req, 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rst mem_req", mem_req, 0);
        chk("rst inst_ready", inst_ready, 1);
        chk("rst done", done, 0);
        sb.delete();
        mq.delete();
        for (int i = 0; i < 32; i++) mreg[i] = 0;
        for (int k = 0; k < 160; k++) begin
            int kind = $urandom_range(0, 3);
            logic [4:0] rs = 5'($urandom), rt = 5'($urandom);
            logic [15:0] imm = 16'($urandom);
            int wt = $urandom_range(0, 4);
            if (k < 12) issue(1, 0, 1, 1, 0, 0, 4'b0010, 0, rt, imm, 0);
            else if (kind == 0) issue(1, 1'($urandom), 1'($urandom), 1, 0, 1, ops[$urandom_range(0, 6)], rs, rt, imm, wt);
            else if (kind == 1) issue(1'($urandom), 0, 1'($urandom), 1'($urandom), 1, 0, ops[$urandom_range(0, 6)], rs, rt, imm, wt);
            else issue(1, 1'($urandom), 1'($urandom), 1'($urandom), 0, 0, ops[$urandom_range(0, 6)], rs, rt, imm, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        n = 0;
        while ((sb.size() != 0 || pend) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain pending", sb.size(), 0);
        mon_en = 0;
        for (int i = 0; i < 32; i++) begin
            main_dbg = 5'(i);
            #1;
            chk($sformatf("final R%0d", i), dbg_rdata, mreg[i]);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
